// File: rtl/hilo_mul_controller_if.sv
// rtl/hilo_mul_controller_if.sv - EX-stage issue / multiplier / HI-LO bus for hilo_mul_controller
//   op_valid, op_ready, op_code, op_src1, op_src2, flush : operation handshake from the EX stage
//   mul_is_signed, mul_input1, mul_input2, mul_result     : link to the external multiplier
//   rd_valid, rd_data                                     : MFHI/MFLO read return
//   busy, hi, lo                                          : status and architectural HI/LO
//   slave modport is the controller's view; master is the environment's view.
interface hilo_mul_controller_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        flush;
    logic        mul_is_signed;
    logic [31:0] mul_input1;
    logic [31:0] mul_input2;
    logic [63:0] mul_result;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, flush, mul_result,
        output op_ready, mul_is_signed, mul_input1, mul_input2,
               rd_valid, rd_data, busy, hi, lo
    );

    modport master (
        output op_valid, op_code, op_src1, op_src2, flush, mul_result,
        input  op_ready, mul_is_signed, mul_input1, mul_input2,
               rd_valid, rd_data, busy, hi, lo
    );
endinterface

// File: rtl/hilo_mul_controller.sv
// rtl/hilo_mul_controller.sv - HI/LO owner and sequencer for the pipelined EX-stage multiplier
//   clock : rising-edge system clock
//   reset : asynchronous active-high reset
//   bus   : hilo_mul_controller_if.slave (op handshake, multiplier link, read return, HI/LO)
module hilo_mul_controller #(
    parameter int MUL_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    hilo_mul_controller_if.slave   bus
);
    localparam int CW = $clog2(MUL_LATENCY + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi_q;
    logic [31:0]    lo_q;
    logic [31:0]    in1_q;
    logic [31:0]    in2_q;
    logic           signed_q;
    logic           rd_valid_q;
    logic [31:0]    rd_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            signed_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // Read pulse is single-cycle; flush also lands here since nothing re-asserts it.
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // op_ready is implied in IDLE once reset is low.
                    if (bus.op_valid && !bus.flush) begin
                        case (bus.op_code)
                            OP_MULT, OP_MULTU: begin
                                in1_q    <= bus.op_src1;
                                in2_q    <= bus.op_src2;
                                signed_q <= (bus.op_code == OP_MULT);
                                cnt      <= CW'(MUL_LATENCY);
                                state    <= MUL_WAIT;
                            end
                            OP_MTHI: hi_q <= bus.op_src1;
                            OP_MTLO: lo_q <= bus.op_src1;
                            OP_MFHI: begin
                                rd_data_q  <= hi_q;
                                rd_valid_q <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data_q  <= lo_q;
                                rd_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL_WAIT: begin
                    if (bus.flush) begin
                        // Abort wins over a coincident write-back; HI/LO untouched.
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        hi_q  <= bus.mul_result[63:32];
                        lo_q  <= bus.mul_result[31:0];
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_ready      = !reset && (state == IDLE);
    assign bus.busy          = (state == MUL_WAIT);
    assign bus.mul_is_signed = signed_q;
    assign bus.mul_input1    = in1_q;
    assign bus.mul_input2    = in2_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;
endmodule
